// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_seq
//  Purpose  : Multi-cycle unsigned multiply / divide unit with a
//             start/busy/done handshake. One radix-2 step per clock.
//             MUL : R = A[H-1:0] * B           (exact in WIDTH bits)
//             DIV : R = {A % B, A / B}         (H-bit remainder/quotient)
//             DIV by zero or quotient overflow resolves in one cycle.
//  Ports    : clk      - system clock, rising edge
//             reset_n  - asynchronous active-low reset
//             start    - request, sampled only while idle
//             op       - 0 = MUL, 1 = DIV
//             A        - WIDTH-bit multiplicand (low half) / dividend
//             B        - H-bit multiplier / divisor
//             busy     - iteration in progress
//             done     - one-cycle pulse, R/flags updated this cycle
//             R        - WIDTH-bit result
//             flags    - {S,V,C,Z}
//  Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH/2-1:0] B,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   R,
  output logic [3:0]         flags
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(H + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CALC = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic [WIDTH-1:0] acc;     // MUL: partial product; DIV: {remainder, quotient/dividend}
  logic [WIDTH-1:0] mcand;   // MUL: multiplicand, shifted left each step
  logic [H-1:0]     opb;     // MUL: multiplier, shifted right; DIV: divisor, static

  logic             accept;
  logic             div_zero;
  logic             div_ovf;
  logic             early;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [H:0]       div_trial;
  logic [H:0]       div_sub;
  logic             div_ge;
  logic [H-1:0]     div_rem_nxt;
  logic [WIDTH-1:0] div_acc_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic [3:0]       flags_nxt;

  assign accept   = (state == ST_IDLE) && start;
  assign div_zero = (B == '0);
  // Quotient fits in H bits only when the dividend's upper half is below the divisor.
  assign div_ovf  = (A[WIDTH-1:H] >= B);
  assign early    = op && (div_zero || div_ovf);

  // --------------------------------------------------------------------------
  // One iteration step for both operations
  // --------------------------------------------------------------------------
  always_comb begin
    mul_acc_nxt = acc + (opb[0] ? mcand : '0);
    // Restoring division: shift the next dividend bit into the partial remainder.
    // The remainder is always below the divisor, so the trial fits in H+1 bits
    // and the restored/subtracted remainder fits back in H bits.
    div_trial   = {acc[WIDTH-1:H], acc[H-1]};
    div_sub     = div_trial - {1'b0, opb};
    div_ge      = (div_trial >= {1'b0, opb});
    div_rem_nxt = div_ge ? div_sub[H-1:0] : div_trial[H-1:0];
    div_acc_nxt = {div_rem_nxt, acc[H-2:0], div_ge};
    acc_nxt     = op_q ? div_acc_nxt : mul_acc_nxt;
    if (op_q) begin
      flags_nxt = {acc_nxt[H-1], 2'b00, (acc_nxt[H-1:0] == '0)};
    end else begin
      flags_nxt = {acc_nxt[WIDTH-1], 2'b00, (acc_nxt == '0)};
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && !early) state_nxt = ST_CALC;
      ST_CALC: if (cnt == CW'(1))    state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy = (state == ST_CALC);
  end

  // --------------------------------------------------------------------------
  // Datapath and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      op_q  <= 1'b0;
      acc   <= '0;
      mcand <= '0;
      opb   <= '0;
      done  <= 1'b0;
      R     <= '0;
      flags <= 4'b0000;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (early) begin
          // Divide-by-zero reports S=1; overflow mirrors the dividend sign bit.
          R     <= A;
          flags <= {(div_zero ? 1'b1 : A[WIDTH-1]), 1'b1, 1'b0, 1'b0};
          done  <= 1'b1;
        end else begin
          op_q  <= op;
          acc   <= op ? A : '0;
          mcand <= {{H{1'b0}}, A[H-1:0]};
          opb   <= B;
          cnt   <= CW'(H);
        end
      end else if (state == ST_CALC) begin
        acc   <= acc_nxt;
        mcand <= mcand << 1;
        opb   <= op_q ? opb : (opb >> 1);
        cnt   <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          R     <= acc_nxt;
          flags <= flags_nxt;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv_seq
//  Purpose  : Self-checking bench for alu_muldiv_seq at WIDTH=16 and WIDTH=32.
//             Expected results come from plain integer arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        wide;
  logic        op_in;
  logic [31:0] a_bus;
  logic [15:0] b_bus;

  logic        start16;
  logic        start32;
  logic        busy16, done16, busy32, done32;
  logic [15:0] r16;
  logic [31:0] r32;
  logic [3:0]  flags16, flags32;

  int          tests;
  int          fails;
  logic [31:0] prev16;
  logic [31:0] prev32;

  assign start16 = start & ~wide;
  assign start32 = start & wide;

  alu_muldiv_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .op(op_in),
    .A(a_bus[15:0]), .B(b_bus[7:0]),
    .busy(busy16), .done(done16), .R(r16), .flags(flags16)
  );

  alu_muldiv_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .op(op_in),
    .A(a_bus), .B(b_bus),
    .busy(busy32), .done(done32), .R(r32), .flags(flags32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation starting in the current cycle and follow it to done.
  // Returns right after sampling the done cycle, so a following call starts
  // in the done cycle (back-to-back).
  task automatic run(input bit wd, input bit o, input logic [31:0] a,
                     input logic [15:0] b, input bit spam, input string tag);
    int          w, h, lat;
    logic [31:0] am, bm, hmask, q, r, exp_r, prev, cr;
    logic [3:0]  exp_f, cf;
    logic        cb, cd, seen, prof_ok, hold_ok;
    w     = wd ? 32 : 16;
    h     = w / 2;
    am    = wd ? a : (a & 32'h0000_FFFF);
    bm    = wd ? {16'h0, b} : {24'h0, b[7:0]};
    hmask = wd ? 32'h0000_FFFF : 32'h0000_00FF;
    prev  = wd ? prev32 : prev16;

    if (!o) begin
      exp_r = (am & hmask) * bm;
      exp_f = {exp_r[w-1], 2'b00, (exp_r == 0)};
      lat   = h + 1;
    end else if (bm == 0) begin
      exp_r = am;
      exp_f = 4'b1100;
      lat   = 1;
    end else if ((am >> h) >= bm) begin
      exp_r = am;
      exp_f = {am[w-1], 3'b100};
      lat   = 1;
    end else begin
      q     = am / bm;
      r     = am % bm;
      exp_r = (r << h) | q;
      exp_f = {q[h-1], 2'b00, (q == 0)};
      lat   = h + 1;
    end

    wide  = wd;
    op_in = o;
    a_bus = a;
    b_bus = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_bus = $urandom;
    b_bus = 16'($urandom);
    op_in = 1'($urandom);

    seen = 0; prof_ok = 1; hold_ok = 1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      start = (spam && c >= 3 && c <= 7);
      @(negedge clk);
      cb = wd ? busy32 : busy16;
      cd = wd ? done32 : done16;
      cr = wd ? r32 : {16'h0, r16};
      cf = wd ? flags32 : flags16;
      if (cb !== (lat > 1 && c <= h) || cd !== (c == lat)) prof_ok = 0;
      if (cd === 1'b1) seen = 1;
      else if (cr !== prev) hold_ok = 0;
      if (!seen) begin
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;

    chk({tag, ":done_seen"}, 32'(seen), 32'd1);
    chk({tag, ":timing"},    32'(prof_ok), 32'd1);
    chk({tag, ":R_hold"},    32'(hold_ok), 32'd1);
    chk({tag, ":R"},         cr, exp_r);
    chk({tag, ":flags"},     {28'h0, cf}, {28'h0, exp_f});
    if (wd) prev32 = exp_r; else prev16 = exp_r;
  endtask

  initial begin
    logic nodone;
    tests   = 0;
    fails   = 0;
    prev16  = 0;
    prev32  = 0;
    start   = 0;
    wide    = 0;
    op_in   = 0;
    a_bus   = 0;
    b_bus   = 0;
    reset_n = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst:busy16", {31'h0, busy16}, 32'h0);
    chk("rst:done16", {31'h0, done16}, 32'h0);
    chk("rst:R16",    {16'h0, r16}, 32'h0);
    chk("rst:flags16", {28'h0, flags16}, 32'h0);
    chk("rst:R32",    r32, 32'h0);
    chk("rst:flags32", {28'h0, flags32}, 32'h0);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Directed cases
    run(0, 0, 32'h0000_00FF, 16'h00FF, 0, "mul_ff_ff");
    run(0, 1, 32'h0000_1234, 16'h0056, 0, "div_1234_56");
    run(0, 1, 32'h0000_1234, 16'h0000, 0, "div_by_zero");
    run(0, 1, 32'h0000_5600, 16'h0056, 0, "div_ovf");
    run(0, 0, 32'h0000_AB00, 16'h0000, 1, "mul_zero_spam");

    // Reset in the middle of a multiply
    @(posedge clk);
    #1;
    wide = 0; op_in = 0; a_bus = 32'h0000_0077; b_bus = 16'h0033;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 0;
    #1;
    chk("midrst:busy",  {31'h0, busy16}, 32'h0);
    chk("midrst:done",  {31'h0, done16}, 32'h0);
    chk("midrst:R",     {16'h0, r16}, 32'h0);
    chk("midrst:flags", {28'h0, flags16}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1;
    prev16 = 0;
    prev32 = 0;
    nodone = 1;
    repeat (12) begin
      @(negedge clk);
      if (done16 !== 1'b0 || busy16 !== 1'b0) nodone = 0;
    end
    chk("midrst:no_done", {31'h0, nodone}, 32'h1);
    run(0, 0, 32'h0000_1234, 16'h00C5, 0, "mul_after_rst");

    // Wide instance
    run(1, 0, 32'h0000_FFFF, 16'hFFFF, 0, "mul32_ffff");
    run(1, 1, 32'h1234_5678, 16'h9ABC, 0, "div32_norm");

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      bit          wd, o, sp;
      logic [31:0] a;
      logic [15:0] b;
      wd = 1'($urandom);
      o  = 1'($urandom);
      sp = ($urandom_range(0, 3) == 0);
      a  = $urandom;
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 0;
      if (o && $urandom_range(0, 1) == 1) begin
        a = wd ? {1'b0, a[30:0] >> $urandom_range(1, 16)} : (a >> $urandom_range(1, 8));
      end
      run(wd, o, a, b, sp, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised, multi-cycle successor to the single-cycle ALU MUL/DIV paths.
- Performs an unsigned HxH->WIDTH multiply and an unsigned WIDTH/H divide (H = WIDTH/2) with radix-2 iteration, one bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the combinational ALU in the CPU execute stage. The sequencer stalls on busy and writes R/flags back on done.
- Flag encoding matches the ALU: bit0 Z, bit1 C, bit2 V, bit3 S.

Parameters:
- WIDTH, 16, result/dividend width; must be even and >= 8; H = WIDTH/2 is the multiplicand/divisor/quotient width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while idle (busy=0)
- op  in  1  0 = MUL, 1 = DIV
- A  in  WIDTH  MUL: A[H-1:0] is the multiplicand, upper bits ignored; DIV: full dividend
- B  in  H  multiplier / divisor
- busy  out  1  iteration in progress
- done  out  1  one-cycle pulse: R/flags updated this cycle
- R  out  WIDTH  MUL: product; DIV: {remainder[H-1:0], quotient[H-1:0]}
- flags  out  4  {S,V,C,Z}

Behaviour:
- Reset (async, reset_n=0): state IDLE; busy=0; done=0; R=0; flags=0; counter and internal accumulators cleared. Reset mid-operation abandons the operation; no done is produced.
- States: IDLE, CALC.
- IDLE, start=1, normal case: on the edge ending cycle 0, latch op/A/B into internal registers, load iteration counter = H, go to CALC.
  - busy=1 in cycles 1..H.
  - On edge H the final iteration completes, state returns to IDLE, R/flags load, done=1 in cycle H+1 and busy=0.
  - Latency from start to done is H+1 cycles for both ops.
- start while busy=1: ignored, with no effect on the running operation. start in the done cycle is accepted, so back-to-back operation is supported.
- R and flags hold the previous result throughout CALC. They change only in the done cycle and then hold until the next done.
- MUL:
  - Shift-add over the H multiplier bits; product is exact in WIDTH bits.
  - R = A[H-1:0]*B.
  - Z = (R==0); S = R[WIDTH-1]; C = 0; V = 0.
- DIV, normal case:
  - Restoring shift-subtract, producing H quotient bits in H iterations.
  - R = {A mod B, A / B}.
  - Z = (quotient==0); S = quotient[H-1]; C = 0; V = 0.
- DIV by zero (B==0): detected on the accept edge; no CALC; busy stays 0.
  - done=1 in cycle 1.
  - R = A; V = 1; S = 1; Z = 0; C = 0.
- DIV overflow (B!=0 and A[WIDTH-1:H] >= B, quotient does not fit in H bits): detected on the accept edge; no CALC.
  - done=1 in cycle 1.
  - R = A; V = 1; S = A[WIDTH-1]; Z = 0; C = 0.
- Early-exit cases (DIV by zero, DIV overflow) take precedence over the normal path. busy never asserts for them.
- done is never asserted together with busy. done is never asserted for two consecutive cycles unless a new start was accepted in the done cycle and that start resolved via an early-exit case.
- Inputs A/B/op may change freely after the accept edge; only the latched copies are used.
- Counter decrements once per CALC edge; no wrap-around, since CALC exits at count 1->0.

Test Plan:
- WIDTH=16, MUL A=0x00FF B=0xFF, start in cycle 0 -> busy cycles 1..8; done cycle 9; R=0xFE01; flags S=1 Z=0 V=0 C=0.
- WIDTH=16, DIV A=0x1234 B=0x56 -> done cycle 9; R=0x1036 (q=0x36, r=0x10); Z=0 S=0 V=0.
- WIDTH=16, DIV A=0x1234 B=0x00 -> busy never high; done cycle 1; R=0x1234; V=1 S=1 Z=0. Then DIV A=0x5600 B=0x56 -> done cycle 1; R=0x5600; V=1 S=0.
- WIDTH=16, MUL A=0xAB00 B=0x00 -> R=0x0000 Z=1. Assert start again in cycles 3..7 -> ignored, single done in cycle 9, R unchanged during cycles 1..8.
- WIDTH=16, start MUL, pull reset_n low in cycle 4 -> busy=0, R=0, flags=0 immediately; no done. New start after release -> normal 9-cycle result.
- WIDTH=32, MUL A=0x0000FFFF B=0xFFFF -> done cycle 17; R=0xFFFE0001; S=1.
